// File: rtl/ahb_gpio_param.sv
// rtl/ahb_gpio_param.sv - AHB-Lite GPIO port with parametrised width, parity and edge interrupts
//
// Purpose:
//   Zero-wait-state AHB-Lite slave exposing a WIDTH-bit GPIO port. Each bit
//   has its own direction. The output bus carries an extra parity bit. The
//   input bus is synchronised and parity-checked. Optional edge-triggered
//   interrupts are built only when the GPIO_IRQ_EN macro is defined. In the
//   default build that logic is absent and GPIOIRQ is tied low.
//
// Parameters:
//   WIDTH       - data bits, 1..32. Pin buses are WIDTH+1 wide, and bit WIDTH
//                 is the parity bit.
//   SYNC_STAGES - input synchroniser depth, 2..4.
//
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HWDATA,
//   HREADY                - AHB-Lite slave inputs (HADDR[4:2] decoded, HSIZE ignored)
//   HRDATA, HREADYOUT,
//   HRESP                 - AHB-Lite slave outputs (always ready, always OKAY)
//   GPIOIN                - input pins plus parity bit
//   PARITYSEL             - 0 = even parity, 1 = odd parity
//   GPIOOUT               - output pins plus generated parity bit
//   GPIODIR               - per-bit direction, 1 = output
//   PARITYERR             - registered live input parity error
//   GPIOIRQ               - registered OR of enabled interrupt status bits
//
// Register map (word offsets):
//   0x00 DATA, 0x04 DIR, 0x08 IRQ_EN, 0x0C IRQ_EDGE, 0x10 IRQ_STATUS (W1C)

module ahb_gpio_param #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    input  logic [WIDTH:0]   GPIOIN,
    input  logic             PARITYSEL,
    output logic [WIDTH:0]   GPIOOUT,
    output logic [WIDTH-1:0] GPIODIR,
    output logic             PARITYERR,
    output logic             GPIOIRQ
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_IRQEN  = 3'd2;
    localparam logic [2:0] ADDR_IRQEDG = 3'd3;
    localparam logic [2:0] ADDR_IRQSTS = 3'd4;

    // Address-phase pipeline register
    logic       ph_valid;
    logic       ph_write;
    logic [2:0] ph_addr;
    logic       addr_take;

    assign addr_take = HSEL & HREADY & HTRANS[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_valid <= 1'b0;
            ph_write <= 1'b0;
            ph_addr  <= 3'd0;
        end else if (addr_take) begin
            ph_valid <= 1'b1;
            ph_write <= HWRITE;
            ph_addr  <= HADDR[4:2];
        end else begin
            ph_valid <= 1'b0;
            ph_write <= 1'b0;
            ph_addr  <= 3'd0;
        end
    end

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;

    assign wr_en = ph_valid & ph_write;
    assign rd_en = ph_valid & ~ph_write;
    assign wdata = HWDATA[WIDTH-1:0];

    // Output data and direction registers
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg <= '0;
            dir_reg <= '0;
        end else if (wr_en) begin
            if (ph_addr == ADDR_DATA) out_reg <= wdata;
            if (ph_addr == ADDR_DIR)  dir_reg <= wdata;
        end
    end

    // Parity bit follows PARITYSEL combinationally so a mode change needs no bus write
    assign GPIOOUT = {(^out_reg) ^ PARITYSEL, out_reg};
    assign GPIODIR = dir_reg;

    // Input synchroniser: all WIDTH+1 pins including the parity bit
    logic [WIDTH:0] sync_q [SYNC_STAGES];
    logic [WIDTH:0] in_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= GPIOIN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    // Live parity check; with PARITYSEL=1 an odd total count of ones is correct
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) PARITYERR <= 1'b0;
        else          PARITYERR <= (^in_sync) ^ PARITYSEL;
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_edge;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] sts_clr;

    // in_prev tracks every bit regardless of direction, so turning a bit into
    // an input compares against its real recent value and fakes no edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) in_prev <= '0;
        else          in_prev <= in_sync[WIDTH-1:0];
    end

    assign rise     = in_sync[WIDTH-1:0] & ~in_prev;
    assign fall     = ~in_sync[WIDTH-1:0] & in_prev;
    assign edge_hit = ((irq_edge & fall) | (~irq_edge & rise)) & ~dir_reg;
    assign sts_clr  = (wr_en && ph_addr == ADDR_IRQSTS) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en   <= '0;
            irq_edge <= '0;
        end else if (wr_en) begin
            if (ph_addr == ADDR_IRQEN)  irq_en   <= wdata;
            if (ph_addr == ADDR_IRQEDG) irq_edge <= wdata;
        end
    end

    // Set is OR-ed in after the clear so a coincident edge is never lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_status <= '0;
        else          irq_status <= (irq_status & ~sts_clr) | edge_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) GPIOIRQ <= 1'b0;
        else          GPIOIRQ <= |(irq_status & irq_en);
    end
`else
    assign GPIOIRQ = 1'b0;
`endif

    // Read data, valid only during a read data phase
    logic [WIDTH-1:0] rd_val;
    logic [31:0]      rd_word;

    always_comb begin
        rd_val = '0;
        case (ph_addr)
            ADDR_DATA:   rd_val = (out_reg & dir_reg) | (in_sync[WIDTH-1:0] & ~dir_reg);
            ADDR_DIR:    rd_val = dir_reg;
`ifdef GPIO_IRQ_EN
            ADDR_IRQEN:  rd_val = irq_en;
            ADDR_IRQEDG: rd_val = irq_edge;
            ADDR_IRQSTS: rd_val = irq_status;
`endif
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (rd_en) rd_word[WIDTH-1:0] = rd_val;
    end

    assign HRDATA    = rd_word;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};

endmodule

// File: tb/tb_ahb_gpio_param.sv
// tb/tb_ahb_gpio_param.sv - self-checking bench for ahb_gpio_param (GPIO_IRQ_EN selects IRQ tests)

module tb_ahb_gpio_param;

    localparam int W = 16;

    localparam logic [31:0] A_DATA = 32'h00;
    localparam logic [31:0] A_DIR  = 32'h04;
    localparam logic [31:0] A_IEN  = 32'h08;
    localparam logic [31:0] A_IEDG = 32'h0C;
    localparam logic [31:0] A_ISTS = 32'h10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [W:0]    GPIOIN;
    logic          PARITYSEL;
    logic [W:0]    GPIOOUT;
    logic [W-1:0]  GPIODIR;
    logic          PARITYERR;
    logic          GPIOIRQ;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];

    ahb_gpio_param #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .GPIOIN    (GPIOIN),
        .PARITYSEL (PARITYSEL),
        .GPIOOUT   (GPIOOUT),
        .GPIODIR   (GPIODIR),
        .PARITYERR (PARITYERR),
        .GPIOIRQ   (GPIOIRQ)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    // Scoreboard consumer: the expected word is queued with the address phase
    // and compared when the data phase presents HRDATA.
    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        logic [31:0] exp_v;
        string       exp_n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge clk);
        exp_v = exp_q.pop_front();
        exp_n = name_q.pop_front();
        checks++;
        if (HRDATA !== exp_v) begin
            errors++;
            $display("FAIL %s: HRDATA got %h expected %h", exp_n, HRDATA, exp_v);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if (GPIOOUT !== 17'h0 || GPIODIR !== 16'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: out %h dir %h rdy %b resp %b expected 0 0 1 0",
                     GPIOOUT, GPIODIR, HREADYOUT, HRESP);
        end
        @(negedge clk); reset_n = 1'b1;
        bus_write(A_DIR, 32'hFFFF);
        bus_write(A_DATA, 32'h0005);
        wait_cycles(1);
        checks++;
        if (GPIOOUT !== 17'h00005) begin
            errors++;
            $display("FAIL pre_reset_out: got %h expected %h", GPIOOUT, 17'h00005);
        end
        // Reset arrives mid-cycle during the data phase of a DIR write
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_DIR;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h00F0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (GPIOOUT !== 17'h0 || GPIODIR !== 16'h0 || PARITYERR !== 1'b0 || GPIOIRQ !== 1'b0
            || HRDATA !== 32'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out %h dir %h perr %b irq %b rdata %h rdy %b resp %b expected 0 0 0 0 0 1 0",
                     GPIOOUT, GPIODIR, PARITYERR, GPIOIRQ, HRDATA, HREADYOUT, HRESP);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_cycles(1);
        checks++;
        if (GPIODIR !== 16'h0) begin
            errors++;
            $display("FAIL reset_dropped_write: GPIODIR got %h expected 0000", GPIODIR);
        end
        bus_read(A_DIR, 32'h0, "reset_dir_read");
    endtask

    task automatic test_output_write;
        PARITYSEL = 1'b0;
        bus_write(A_DIR, 32'hFFFF);
        bus_write(A_DATA, 32'h0007);
        wait_cycles(1);
        checks++;
        if (GPIOOUT !== 17'h10007) begin
            errors++;
            $display("FAIL out_even_parity: got %h expected %h", GPIOOUT, 17'h10007);
        end
        PARITYSEL = 1'b1;
        #1;
        checks++;
        if (GPIOOUT !== 17'h00007) begin
            errors++;
            $display("FAIL out_odd_parity: got %h expected %h", GPIOOUT, 17'h00007);
        end
        bus_read(A_DATA, 32'h0007, "out_data_read");
        bus_read(A_DIR, 32'hFFFF, "out_dir_read");
    endtask

    task automatic test_input_read;
        PARITYSEL = 1'b0;
        bus_write(A_DIR, 32'h0);
        GPIOIN = 17'h0A5A5;
        wait_cycles(4);
        bus_read(A_DATA, 32'hA5A5, "in_data_read");
        checks++;
        if (PARITYERR !== 1'b0) begin
            errors++;
            $display("FAIL in_parity_ok: got %b expected 0", PARITYERR);
        end
        @(posedge clk); #1;
        GPIOIN[W] = 1'b1;
        wait_cycles(2);
        checks++;
        if (PARITYERR !== 1'b0) begin
            errors++;
            $display("FAIL in_parity_early: got %b expected 0", PARITYERR);
        end
        wait_cycles(1);
        checks++;
        if (PARITYERR !== 1'b1) begin
            errors++;
            $display("FAIL in_parity_err: got %b expected 1", PARITYERR);
        end
        PARITYSEL = 1'b1;
        wait_cycles(1);
        checks++;
        if (PARITYERR !== 1'b0) begin
            errors++;
            $display("FAIL in_parity_odd: got %b expected 0", PARITYERR);
        end
        PARITYSEL = 1'b0;
    endtask

    task automatic test_mixed_dir;
        bus_write(A_DIR, 32'h00FF);
        bus_write(A_DATA, 32'h1234);
        GPIOIN = 17'h0ABCD;
        wait_cycles(4);
        bus_read(A_DATA, 32'hAB34, "mixed_data_read");
        checks++;
        if (GPIOOUT !== 17'h11234) begin
            errors++;
            $display("FAIL mixed_out: got %h expected %h", GPIOOUT, 17'h11234);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_v;
        string       exp_n;
        exp_q.push_back(32'h0F0F);
        name_q.push_back("b2b_dir_read");
        @(posedge clk); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_DIR;
        @(posedge clk); #1;
        HWDATA = 32'h0F0F; HTRANS = 2'b11; HWRITE = 1'b0; HADDR = A_DIR;
        @(posedge clk); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge clk);
        exp_v = exp_q.pop_front();
        exp_n = name_q.pop_front();
        checks++;
        if (HRDATA !== exp_v) begin
            errors++;
            $display("FAIL %s: HRDATA got %h expected %h", exp_n, HRDATA, exp_v);
        end
        bus_write(32'h1C, 32'hFFFF);
        bus_read(32'h1C, 32'h0, "unmapped_1c_read");
        bus_read(32'h14, 32'h0, "unmapped_14_read");
        bus_read(A_DIR, 32'h0F0F, "dir_after_unmapped");
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_rising_irq;
        bus_write(A_DIR, 32'h0);
        GPIOIN = 17'h0;
        wait_cycles(5);
        bus_write(A_IEDG, 32'h0);
        bus_write(A_ISTS, 32'hFFFF);
        bus_write(A_IEN, 32'h0001);
        bus_read(A_ISTS, 32'h0, "rise_status_clear");
        @(posedge clk); #1;
        GPIOIN[0] = 1'b1;
        wait_cycles(3);
        checks++;
        if (GPIOIRQ !== 1'b0) begin
            errors++;
            $display("FAIL rise_irq_early: got %b expected 0", GPIOIRQ);
        end
        wait_cycles(1);
        checks++;
        if (GPIOIRQ !== 1'b1) begin
            errors++;
            $display("FAIL rise_irq: got %b expected 1", GPIOIRQ);
        end
        bus_read(A_ISTS, 32'h0001, "rise_status");
        bus_write(A_ISTS, 32'h0001);
        wait_cycles(2);
        checks++;
        if (GPIOIRQ !== 1'b0) begin
            errors++;
            $display("FAIL rise_w1c_irq: got %b expected 0", GPIOIRQ);
        end
        // Edge on bit 3 lands in status on the same edge as the W1C write
        @(posedge clk); #1;
        GPIOIN[3] = 1'b1;
        bus_write(A_ISTS, 32'h0008);
        bus_read(A_ISTS, 32'h0008, "set_beats_clear");
        bus_write(A_ISTS, 32'h0008);
        bus_read(A_ISTS, 32'h0, "w1c_clears");
    endtask

    task automatic test_falling_gating;
        bus_write(A_IEDG, 32'h0002);
        GPIOIN[1] = 1'b1;
        wait_cycles(5);
        bus_read(A_ISTS, 32'h0, "fall_rise_ignored");
        GPIOIN[1] = 1'b0;
        wait_cycles(5);
        bus_read(A_ISTS, 32'h0002, "fall_status");
        checks++;
        if (GPIOIRQ !== 1'b0) begin
            errors++;
            $display("FAIL fall_irq_masked: got %b expected 0", GPIOIRQ);
        end
        bus_write(A_DIR, 32'h0004);
        bus_write(A_ISTS, 32'hFFFF);
        GPIOIN[2] = 1'b1;
        wait_cycles(5);
        GPIOIN[2] = 1'b0;
        wait_cycles(5);
        GPIOIN[2] = 1'b1;
        wait_cycles(5);
        bus_write(A_DIR, 32'h0);
        wait_cycles(5);
        bus_read(A_ISTS, 32'h0, "dir_gating");
    endtask
`else
    task automatic test_irq_disabled;
        bus_write(A_DIR, 32'h0);
        bus_write(A_IEN, 32'hFFFF);
        bus_write(A_IEDG, 32'hFFFF);
        GPIOIN = 17'h0;
        wait_cycles(5);
        GPIOIN = 17'h0FFFF;
        wait_cycles(6);
        checks++;
        if (GPIOIRQ !== 1'b0) begin
            errors++;
            $display("FAIL noirq_pin: got %b expected 0", GPIOIRQ);
        end
        bus_read(A_IEN, 32'h0, "noirq_en_read");
        bus_read(A_IEDG, 32'h0, "noirq_edge_read");
        bus_read(A_ISTS, 32'h0, "noirq_status_read");
        bus_read(A_DATA, 32'hFFFF, "noirq_data_read");
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        HSEL      = 1'b0;
        HADDR     = 32'h0;
        HTRANS    = 2'b00;
        HWRITE    = 1'b0;
        HSIZE     = 3'b010;
        HWDATA    = 32'h0;
        HREADY    = 1'b1;
        GPIOIN    = '0;
        PARITYSEL = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_output_write;
        test_input_read;
        test_mixed_dir;
        test_back_to_back;
`ifdef GPIO_IRQ_EN
        test_rising_irq;
        test_falling_gating;
`else
        test_irq_disabled;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
